// File: rtl/vga_pkg.sv
// Shared definitions for the VGA text-mode character fetch path.
package vga_pkg;

    // Default text-screen geometry: 640x480 visible, 10x16 pixel cells.
    localparam int COLS_DEF   = 64;
    localparam int ROWS_DEF   = 30;
    localparam int CHAR_W_DEF = 10;
    localparam int CHAR_H_DEF = 16;

    // Fixed field widths seen on the block's ports.
    localparam int COL_W   = 6;
    localparam int ROW_W   = 5;
    localparam int SCAN_W  = 4;
    localparam int TXT_AW  = 11;
    localparam int FONT_AW = 12;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } fetch_state_e;

    // Text RAM address of a cell; everything is widened before the multiply
    // so no partial product is truncated.
    function automatic logic [TXT_AW-1:0] cell_addr(
        input logic [ROW_W-1:0] row,
        input logic [COL_W-1:0] col,
        input int unsigned      cols
    );
        logic [TXT_AW-1:0] row_ext;
        logic [TXT_AW-1:0] col_ext;
        logic [TXT_AW-1:0] cols_ext;
        row_ext  = TXT_AW'(row);
        col_ext  = TXT_AW'(col);
        cols_ext = TXT_AW'(cols);
        return row_ext * cols_ext + col_ext;
    endfunction

endpackage

// File: rtl/vga_text_row_cnt.sv
// Tracks which text row and which scanline inside that row is being drawn.
module vga_text_row_cnt
    import vga_pkg::*;
#(
    parameter int ROWS   = ROWS_DEF,
    parameter int CHAR_H = CHAR_H_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_frame_clr_h,
    input  logic              i_line_done_h,
    output logic [ROW_W-1:0]  o_row,
    output logic [SCAN_W-1:0] o_scanline
);

    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(CHAR_H - 1);

    logic [ROW_W-1:0]  row_reg;
    logic [SCAN_W-1:0] scan_reg;

    // Frame clear wins over a completed line; otherwise step scanline, then row.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            row_reg  <= '0;
            scan_reg <= '0;
        end else if (i_frame_clr_h) begin
            row_reg  <= '0;
            scan_reg <= '0;
        end else if (i_line_done_h) begin
            if (scan_reg == SCAN_LAST) begin
                scan_reg <= '0;
                row_reg  <= (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
            end else begin
                scan_reg <= scan_reg + 1'b1;
            end
        end
    end

    assign o_row      = row_reg;
    assign o_scanline = scan_reg;

endmodule

// File: rtl/vga_char_fetch.sv
// Per-cell text RAM / font ROM fetch sequencer feeding a 10-bit pixel shifter.
// Each cell takes CHAR_W slots: address text RAM, address font ROM, capture
// the font row (or cursor bar), then present it with a load strobe.
module vga_char_fetch
    import vga_pkg::*;
#(
    parameter int COLS   = COLS_DEF,
    parameter int ROWS   = ROWS_DEF,
    parameter int CHAR_W = CHAR_W_DEF,
    parameter int CHAR_H = CHAR_H_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_frame_start_h,
    input  logic               i_line_start_h,
    output logic [TXT_AW-1:0]  o_txt_addr,
    input  logic [7:0]         i_txt_data,
    output logic [FONT_AW-1:0] o_font_addr,
    input  logic [7:0]         i_font_data,
    input  logic               i_cursor_en_h,
    input  logic [COL_W-1:0]   i_cursor_col,
    input  logic [ROW_W-1:0]   i_cursor_row,
    output logic [9:0]         o_data,
    output logic               o_ld_h,
    output logic               o_cs_h
);

    localparam int SW = $clog2(CHAR_W);
    localparam logic [SW-1:0]     S_LAST    = SW'(CHAR_W - 1);
    localparam logic [SW-1:0]     S_PRELOAD = SW'(CHAR_W - 2);
    localparam logic [SW-1:0]     S_CHAR    = SW'(1);
    localparam logic [SW-1:0]     S_FONT    = SW'(2);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
    localparam logic [SCAN_W-1:0] SCAN_CUR  = SCAN_W'(CHAR_H - 2);

    fetch_state_e      state_reg;
    logic [SW-1:0]     s_reg;
    logic [SW-1:0]     tail_reg;
    logic [COL_W-1:0]  col_reg;
    logic [7:0]        char_reg;
    logic [9:0]        stage_reg;
    logic [9:0]        data_reg;
    logic              ld_reg;
    logic              cs_reg;

    logic [ROW_W-1:0]  row;
    logic [SCAN_W-1:0] scanline;
    logic              line_done;
    logic              cursor_hit;

    // Last load of the line; a simultaneous restart strobe suppresses the advance.
    assign line_done = (state_reg == ST_FETCH) && (s_reg == S_LAST) &&
                       (col_reg == COL_LAST) && !i_line_start_h;

    assign cursor_hit = i_cursor_en_h && (col_reg == i_cursor_col) &&
                        (row == i_cursor_row) && (scanline >= SCAN_CUR);

    vga_text_row_cnt #(
        .ROWS   (ROWS),
        .CHAR_H (CHAR_H)
    ) u_row_cnt (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_frame_clr_h (i_frame_start_h),
        .i_line_done_h (line_done),
        .o_row         (row),
        .o_scanline    (scanline)
    );

    // Cell sequencer: slot/column counters, data capture, load and span strobes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= ST_IDLE;
            s_reg     <= '0;
            tail_reg  <= '0;
            col_reg   <= '0;
            char_reg  <= '0;
            stage_reg <= '0;
            data_reg  <= '0;
            ld_reg    <= 1'b0;
            cs_reg    <= 1'b0;
        end else begin
            ld_reg <= 1'b0;
            if (i_line_start_h) begin
                // Covers both a fresh line and a restart mid-line.
                state_reg <= ST_FETCH;
                s_reg     <= '0;
                col_reg   <= '0;
                tail_reg  <= '0;
                cs_reg    <= 1'b0;
            end else if (i_frame_start_h) begin
                state_reg <= ST_IDLE;
                s_reg     <= '0;
                col_reg   <= '0;
                tail_reg  <= '0;
                cs_reg    <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        // Keep the span open until the last cell has shifted out.
                        if (tail_reg != '0) begin
                            tail_reg <= tail_reg - 1'b1;
                            if (tail_reg == SW'(1)) begin
                                cs_reg <= 1'b0;
                            end
                        end
                    end
                    ST_FETCH: begin
                        if (s_reg == S_CHAR) begin
                            char_reg <= i_txt_data;
                        end
                        if (s_reg == S_FONT) begin
                            stage_reg <= cursor_hit ? {8'hFF, 2'b00} : {i_font_data, 2'b00};
                        end
                        if (s_reg == S_PRELOAD) begin
                            ld_reg   <= 1'b1;
                            data_reg <= stage_reg;
                            if (col_reg == '0) begin
                                cs_reg <= 1'b1;
                            end
                        end
                        if (s_reg == S_LAST) begin
                            s_reg <= '0;
                            if (col_reg == COL_LAST) begin
                                state_reg <= ST_IDLE;
                                col_reg   <= '0;
                                tail_reg  <= S_LAST;
                            end else begin
                                col_reg <= col_reg + 1'b1;
                            end
                        end else begin
                            s_reg <= s_reg + 1'b1;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    // The font address must be valid in the slot the RAM data arrives, so the
    // character is forwarded straight from the RAM in that slot.
    always_comb begin
        if ((state_reg == ST_FETCH) && (s_reg == S_CHAR)) begin
            o_font_addr = {i_txt_data, scanline};
        end else begin
            o_font_addr = {char_reg, scanline};
        end
    end

    assign o_txt_addr = cell_addr(row, col_reg, COLS);
    assign o_data     = data_reg;
    assign o_ld_h     = ld_reg;
    assign o_cs_h     = cs_reg;

endmodule

// File: tb/tb_vga_char_fetch.sv
// Randomized self-checking bench for vga_char_fetch with external RAM/ROM models.
module tb_vga_char_fetch;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_frame_start_h;
    logic        i_line_start_h;
    logic [10:0] o_txt_addr;
    logic [7:0]  i_txt_data;
    logic [11:0] o_font_addr;
    logic [7:0]  i_font_data;
    logic        i_cursor_en_h;
    logic [5:0]  i_cursor_col;
    logic [4:0]  i_cursor_row;
    logic [9:0]  o_data;
    logic        o_ld_h;
    logic        o_cs_h;

    always #5 i_clk = ~i_clk;

    vga_char_fetch dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_frame_start_h (i_frame_start_h),
        .i_line_start_h  (i_line_start_h),
        .o_txt_addr      (o_txt_addr),
        .i_txt_data      (i_txt_data),
        .o_font_addr     (o_font_addr),
        .i_font_data     (i_font_data),
        .i_cursor_en_h   (i_cursor_en_h),
        .i_cursor_col    (i_cursor_col),
        .i_cursor_row    (i_cursor_row),
        .o_data          (o_data),
        .o_ld_h          (o_ld_h),
        .o_cs_h          (o_cs_h)
    );

    // External synchronous memories: one cycle from address to data.
    logic [7:0] txt_mem  [0:2047];
    logic [7:0] font_mem [0:4095];

    always @(posedge i_clk) begin
        i_txt_data  <= txt_mem[o_txt_addr];
        i_font_data <= font_mem[o_font_addr];
    end

    int checks   = 0;
    int failures = 0;
    int m_line   = 0;   // visible text lines completed since the frame began

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected shifter word for cell k of the current line.
    function automatic logic [9:0] exp_word(input int row, input int scan, input int k);
        logic [7:0]  ch;
        logic [7:0]  f;
        logic [11:0] fa;
        ch = txt_mem[row * 64 + k];
        fa = {ch, 4'(scan)};
        f  = font_mem[fa];
        if (i_cursor_en_h && k == int'(i_cursor_col) && row == int'(i_cursor_row) && scan >= 14)
            f = 8'hFF;
        return {f, 2'b00};
    endfunction

    // One line strobe (optionally with frame strobe), then ncyc checked cycles.
    // ncyc >= 660 means the line runs to completion.
    task automatic run_line(input bit with_frame, input int ncyc);
        int row, scan, loads, k;
        bit ld_exp, cs_exp;
        logic [11:0] fa_exp;
        @(posedge i_clk); #1;
        i_line_start_h  = 1'b1;
        i_frame_start_h = with_frame;
        if (with_frame) m_line = 0;
        row   = (m_line / 16) % 30;
        scan  = m_line % 16;
        loads = 0;
        @(posedge i_clk); #1;
        i_line_start_h  = 1'b0;
        i_frame_start_h = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            if (c > 1) begin
                @(posedge i_clk); #1;
            end
            #1;
            ld_exp = (c % 10 == 0) && (c <= 640);
            cs_exp = (c >= 10) && (c <= 649);
            chk("ld", 32'(o_ld_h), 32'(ld_exp));
            chk("cs", 32'(o_cs_h), 32'(cs_exp));
            if (ld_exp) begin
                k = c / 10 - 1;
                chk("data", 32'(o_data), 32'(exp_word(row, scan, k)));
            end
            if ((c - 1) % 10 == 0 && c <= 631)
                chk("txt_addr", 32'(o_txt_addr), 32'(row * 64 + (c - 1) / 10));
            if ((c - 2) % 10 == 0 && c <= 632) begin
                k = (c - 2) / 10;
                fa_exp = {txt_mem[row * 64 + k], 4'(scan)};
                chk("font_addr", 32'(o_font_addr), 32'(fa_exp));
            end
            if (o_ld_h) loads++;
        end
        if (ncyc >= 660) begin
            chk("load_count", 32'(loads), 32'd64);
            m_line++;
        end
        $display("line row=%0d scan=%0d frame=%0d cycles=%0d loads=%0d", row, scan, with_frame, ncyc, loads);
    endtask

    // Idle cycles in which no load and no span may appear.
    task automatic check_quiet(input string tag, input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge i_clk); #2;
            chk(tag, {30'd0, o_ld_h, o_cs_h}, 32'd0);
        end
    endtask

    task automatic frame_only();
        @(posedge i_clk); #1;
        i_frame_start_h = 1'b1;
        @(posedge i_clk); #1;
        i_frame_start_h = 1'b0;
        m_line = 0;
        #1;
        chk("frame_ld", 32'(o_ld_h), 32'd0);
        chk("frame_cs", 32'(o_cs_h), 32'd0);
        chk("frame_addr", 32'(o_txt_addr), 32'd0);
        $display("frame strobe");
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_txt"},  32'(o_txt_addr),  32'd0);
        chk({tag, "_font"}, 32'(o_font_addr), 32'd0);
        chk({tag, "_data"}, 32'(o_data),      32'd0);
        chk({tag, "_ld"},   32'(o_ld_h),      32'd0);
        chk({tag, "_cs"},   32'(o_cs_h),      32'd0);
    endtask

    initial begin
        i_rst_n         = 1'b0;
        i_frame_start_h = 1'b0;
        i_line_start_h  = 1'b0;
        i_cursor_en_h   = 1'b0;
        i_cursor_col    = '0;
        i_cursor_row    = '0;
        for (int i = 0; i < 2048; i++) txt_mem[i] = 8'h41;
        for (int i = 0; i < 4096; i++) font_mem[i] = 8'h3C;

        // Reset state.
        repeat (3) @(posedge i_clk);
        #2;
        check_all_zero("reset");
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        check_quiet("post_reset_quiet", 8);

        // Constant 'A' / 0x3C line: loads every 10 cycles carrying 10'h0F0.
        run_line(1'b0, 660);

        // Random screen and font, cursor at column 5 row 0, one full text row plus.
        for (int i = 0; i < 2048; i++) txt_mem[i] = 8'($urandom);
        for (int i = 0; i < 4096; i++) font_mem[i] = 8'($urandom);
        font_mem[{txt_mem[5], 4'd13}] = 8'h00;
        font_mem[{txt_mem[5], 4'd14}] = 8'h00;
        font_mem[{txt_mem[5], 4'd15}] = 8'h00;
        i_cursor_en_h = 1'b1;
        i_cursor_col  = 6'd5;
        i_cursor_row  = 5'd0;
        frame_only();
        for (int l = 0; l < 17; l++) run_line(1'b0, 660);

        // Restart mid-line at column 20: same row/scanline, full 64 loads.
        run_line(1'b0, 205);
        run_line(1'b0, 660);

        // Frame and line together mid-line: fetch restarts at row 0 scanline 0.
        run_line(1'b0, 300);
        run_line(1'b1, 660);

        // Frame alone mid-line aborts the fetch.
        run_line(1'b0, 300);
        frame_only();
        check_quiet("abort_quiet", 20);

        // Random cursor positions in the first text row.
        for (int l = 0; l < 3; l++) begin
            i_cursor_en_h = 1'($urandom_range(0, 1));
            i_cursor_col  = 6'($urandom_range(0, 63));
            i_cursor_row  = 5'd0;
            run_line(1'b0, 660);
        end

        // Asynchronous reset in the middle of a line.
        run_line(1'b0, 30);
        #1;
        i_rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        repeat (3) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        m_line = 0;
        check_quiet("reset_release_quiet", 40);
        run_line(1'b0, 660);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
